// File: rtl/lif_array_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron blocks:
// post-spike reset modes and the saturating adder used by every neuron datapath.
package lif_pkg;

  localparam int RST_ZERO = 0;
  localparam int RST_SUB  = 1;

  // Adds two unsigned operands and clamps the result to the largest w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? 32'(lim) : 32'(sum);
  endfunction

endpackage

// File: rtl/lif_array_if.sv
// Input-beat and spike-event streams of the LIF array, both valid/ready handshakes.
interface lif_array_if #(
  parameter int IDXW = 3,
  parameter int W    = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [IDXW-1:0] in_idx;
  logic [W-1:0]    in_current;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;

  modport master (
    output in_valid, in_idx, in_current, out_ready,
    input  in_ready, out_valid, out_idx
  );

  modport slave (
    input  in_valid, in_idx, in_current, out_ready,
    output in_ready, out_valid, out_idx
  );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, integrate with saturation, threshold
// compare, post-spike reset and refractory bookkeeping.
module lif_update
  import lif_pkg::*;
#(
  parameter int W           = 8,
  parameter int RW          = 2,
  parameter int DECAY_SHIFT = 1,
  parameter int REFRAC      = 2,
  parameter int RESET_MODE  = RST_ZERO
) (
  input  logic [W-1:0]  i_state,
  input  logic [RW-1:0] i_refr,
  input  logic [W-1:0]  i_current,
  input  logic [W-1:0]  i_threshold,
  output logic [W-1:0]  o_state,
  output logic [RW-1:0] o_refr,
  output logic          o_spike
);

  logic [W-1:0] w_u;

  assign w_u = W'(sat_add(32'(i_state >> DECAY_SHIFT), 32'(i_current), W));

  // A refractory neuron ignores its current and only counts down.
  always_comb begin
    o_state = i_state;
    o_refr  = i_refr;
    o_spike = 1'b0;
    if (i_refr != '0) begin
      o_refr = i_refr - 1'b1;
    end else if (w_u >= i_threshold) begin
      o_spike = 1'b1;
      o_state = (RESET_MODE == RST_SUB) ? (w_u - i_threshold) : '0;
      o_refr  = RW'(REFRAC);
    end else begin
      o_state = w_u;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of N LIF neurons sharing one lif_update datapath;
// emits spiking neuron indices through a single output register.
module lif_array
  import lif_pkg::*;
#(
  parameter int N           = 8,
  parameter int W           = 8,
  parameter int DECAY_SHIFT = 1,
  parameter int REFRAC      = 2,
  parameter int RESET_MODE  = RST_ZERO,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  lif_array_if.slave       bus,
  input  logic [W-1:0]     threshold,
  output logic [CNT_W-1:0] spike_count
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [W-1:0]     r_state [N];
  logic [RW-1:0]    r_refr  [N];
  logic             r_out_valid;
  logic [IDXW-1:0]  r_out_idx;
  logic [CNT_W-1:0] r_count;

  logic             w_fire;
  logic             w_idx_ok;
  logic [IDXW-1:0]  w_sel;
  logic [W-1:0]     w_next_state;
  logic [RW-1:0]    w_next_refr;
  logic             w_spike;
  logic             w_spike_ok;

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign spike_count   = r_count;

  assign w_fire     = bus.in_valid && bus.in_ready;
  assign w_idx_ok   = 32'(bus.in_idx) < N;
  assign w_sel      = w_idx_ok ? bus.in_idx : '0;
  assign w_spike_ok = w_spike && w_idx_ok;

  lif_update #(
    .W           (W),
    .RW          (RW),
    .DECAY_SHIFT (DECAY_SHIFT),
    .REFRAC      (REFRAC),
    .RESET_MODE  (RESET_MODE)
  ) u_update (
    .i_state     (r_state[w_sel]),
    .i_refr      (r_refr[w_sel]),
    .i_current   (bus.in_current),
    .i_threshold (threshold),
    .o_state     (w_next_state),
    .o_refr      (w_next_refr),
    .o_spike     (w_spike)
  );

  // Out-of-range indices are consumed but never written back or reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= '0;
        r_refr[i]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_count     <= '0;
    end else begin
      if (w_fire && w_idx_ok) begin
        r_state[w_sel] <= w_next_state;
        r_refr[w_sel]  <= w_next_refr;
      end
      if (w_fire) begin
        r_out_valid <= w_spike_ok;
        if (w_spike_ok) begin
          r_out_idx <= bus.in_idx;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire && w_spike_ok && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: three instances cover the default configuration,
// subtract-on-spike reset and a non-power-of-two neuron count.
module tb_lif_array;
  import lif_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  thr0, thr1, thr2;
  logic [15:0] cnt0, cnt1, cnt2;
  int          nChecks = 0;
  int          nFails  = 0;

  always #5 clk = ~clk;

  lif_array_if #(.IDXW(3), .W(8)) bus0 ();
  lif_array_if #(.IDXW(3), .W(8)) bus1 ();
  lif_array_if #(.IDXW(3), .W(8)) bus2 ();

  lif_array #(.N(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .threshold(thr0), .spike_count(cnt0)
  );
  lif_array #(.N(8), .RESET_MODE(RST_SUB)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .threshold(thr1), .spike_count(cnt1)
  );
  lif_array #(.N(6)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .threshold(thr2), .spike_count(cnt2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one beat on the chosen instance for exactly one clock edge.
  task automatic applyStimulus(input int d, input int idx, input int cur);
    case (d)
      0: begin bus0.in_valid = 1'b1; bus0.in_idx = 3'(idx); bus0.in_current = 8'(cur); end
      1: begin bus1.in_valid = 1'b1; bus1.in_idx = 3'(idx); bus1.in_current = 8'(cur); end
      default: begin bus2.in_valid = 1'b1; bus2.in_idx = 3'(idx); bus2.in_current = 8'(cur); end
    endcase
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
  endtask

  int expV[6]  = '{0, 0, 1, 0, 0, 0};
  int expS[6]  = '{20, 30, 0, 0, 0, 20};
  int expI[6]  = '{0, 0, 3, 3, 3, 3};
  int seq2[6]  = '{1, 2, 1, 2, 1, 2};
  int expV2[6] = '{0, 0, 0, 0, 1, 1};
  int expI2[6] = '{0, 0, 0, 0, 1, 2};

  initial begin
    bus0.in_valid = 1'b0; bus0.in_idx = '0; bus0.in_current = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_idx = '0; bus1.in_current = '0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_idx = '0; bus2.in_current = '0; bus2.out_ready = 1'b1;
    thr0 = 8'd32; thr1 = 8'd32; thr2 = 8'd32;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_valid", bus0.out_valid, 0);
    checkOutput("reset_ready", bus0.in_ready, 1);
    checkOutput("reset_count", cnt0, 0);

    applyStimulus(0, 5, 0);
    checkOutput("idx5_zero_valid", bus0.out_valid, 0);
    checkOutput("idx5_zero_state", dut0.r_state[5], 0);

    // Integrate, fire on the third beat, two refractory beats, then integrate again.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 3, 20);
      checkOutput($sformatf("beat%0d_valid", i + 1), bus0.out_valid, expV[i]);
      checkOutput($sformatf("beat%0d_state", i + 1), dut0.r_state[3], expS[i]);
      checkOutput($sformatf("beat%0d_idx", i + 1), bus0.out_idx, expI[i]);
    end
    checkOutput("fire_count", cnt0, 1);

    thr0 = 8'd255;
    applyStimulus(0, 0, 200);
    checkOutput("sat1_valid", bus0.out_valid, 0);
    checkOutput("sat1_state", dut0.r_state[0], 200);
    applyStimulus(0, 0, 200);
    checkOutput("sat2_valid", bus0.out_valid, 1);
    checkOutput("sat2_idx", bus0.out_idx, 0);
    checkOutput("sat2_state", dut0.r_state[0], 0);
    checkOutput("sat2_count", cnt0, 2);
    thr0 = 8'd32;
    @(posedge clk);
    #1;
    checkOutput("idle_consume_valid", bus0.out_valid, 0);

    bus0.out_ready = 1'b0;
    applyStimulus(0, 1, 40);
    checkOutput("bp_spike_valid", bus0.out_valid, 1);
    checkOutput("bp_spike_idx", bus0.out_idx, 1);
    checkOutput("bp_spike_count", cnt0, 3);
    bus0.in_valid = 1'b1; bus0.in_idx = 3'd2; bus0.in_current = 8'd40;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp%0d_ready", i), bus0.in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d_valid", i), bus0.out_valid, 1);
      checkOutput($sformatf("bp%0d_idx", i), bus0.out_idx, 1);
      checkOutput($sformatf("bp%0d_state2", i), dut0.r_state[2], 0);
      checkOutput($sformatf("bp%0d_count", i), cnt0, 3);
    end
    bus0.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    checkOutput("bp_release_valid", bus0.out_valid, 1);
    checkOutput("bp_release_idx", bus0.out_idx, 2);
    checkOutput("bp_release_count", cnt0, 4);

    // Reset while an event is still pending; the event is dropped.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_valid", bus0.out_valid, 0);
    checkOutput("midrst_count", cnt0, 0);
    applyStimulus(0, 3, 20);
    checkOutput("midrst_redrive_state", dut0.r_state[3], 20);
    checkOutput("midrst_redrive_valid", bus0.out_valid, 0);

    applyStimulus(1, 0, 40);
    checkOutput("sub_valid", bus1.out_valid, 1);
    checkOutput("sub_idx", bus1.out_idx, 0);
    checkOutput("sub_state", dut1.r_state[0], 8);
    checkOutput("sub_count", cnt1, 1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, seq2[i], 20);
      checkOutput($sformatf("n6_beat%0d_valid", i + 1), bus2.out_valid, expV2[i]);
      checkOutput($sformatf("n6_beat%0d_idx", i + 1), bus2.out_idx, expI2[i]);
    end
    checkOutput("n6_count", cnt2, 2);
    applyStimulus(2, 7, 20);
    checkOutput("n6_range_valid", bus2.out_valid, 0);
    checkOutput("n6_range_idx", bus2.out_idx, 2);
    checkOutput("n6_range_count", cnt2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Time-multiplexed array of N leaky integrate-and-fire neurons sharing one update datapath. Each accepted input beat carries a neuron index and an input current. The block updates that neuron's membrane state with a configurable leak, saturation, threshold, post-spike reset mode and refractory period. Only spikes are emitted, as sparse index events behind a valid/ready handshake. It sits between the input-current streamer and the spike-event router in the sparsity-aware pipeline.

## Interface
- N, 8: neuron count. IDXW = max(1, $clog2(N)) is derived.
- W, 8: membrane-state and current width, unsigned.
- DECAY_SHIFT, 1: leak term is state >> DECAY_SHIFT. 1 gives decay 0.5.
- REFRAC, 2: refractory beats after a spike. 0 disables refractory.
- RESET_MODE, 0: 0 sets state to 0 on spike; 1 sets state to u − threshold.
- CNT_W, 16: spike counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_idx  in  IDXW  target neuron.
- in_current  in  W  input current.
- threshold  in  W  firing threshold, sampled on each accepted beat.
- out_valid  out  1  spike event valid.
- out_ready  in  1  downstream accept.
- out_idx  out  IDXW  index of the spiking neuron.
- spike_count  out  CNT_W  total spikes emitted, saturating.

## Operation
- Per-neuron storage: state[N] (W bits) and refr[N] (width to hold REFRAC).
- Accepted beat with in_idx < N, refr[idx] == 0:
  - u = min(state[idx] >> DECAY_SHIFT + in_current, 2^W − 1). Computed at W+1 bits, then saturated.
  - If u ≥ threshold: spike. state[idx] ← (RESET_MODE ? u − threshold : 0). refr[idx] ← REFRAC. Emit event with idx.
  - Otherwise: state[idx] ← u.
- Accepted beat with refr[idx] > 0: current is discarded, state[idx] is unchanged, refr[idx] decrements, no spike.
- Accepted beat with in_idx ≥ N (non-power-of-two N): consumed with no effect.
- Threshold 0: every non-refractory beat spikes.
- Leak is applied only when a neuron receives a beat. Idle neurons do not decay.
- spike_count increments on each emitted event and holds at 2^CNT_W − 1.

## Timing
- Reset values: all state = 0, all refr = 0, out_valid = 0, out_idx = 0, spike_count = 0. in_ready = 1 one cycle after reset deasserts.
- in_ready = !out_valid || out_ready (combinational). A single output register provides full throughput of one beat per cycle.
- Latency: a spike from a beat accepted at edge k gives out_valid = 1 and out_idx valid after edge k.
- An event holds out_valid and out_idx stable until out_valid && out_ready.
- Same-cycle handshakes:
  - Event consumed and a new spiking beat accepted: out_valid stays 1 with the new idx.
  - Event consumed and the beat does not spike: out_valid falls.
- Back-to-back beats to the same idx use the state written on the previous edge. There is no hazard.
- While in_ready = 0, no state, refr or counter changes occur regardless of in_valid.
- rst asserted mid-operation clears everything on the next edge, including a pending event. That event is lost.

## Structure
- Shared package lif_pkg holds:
  - the reset-mode constants RST_ZERO = 0 and RST_SUB = 1;
  - the saturating-add function, shared with other neuron blocks.
- Sub-module lif_update: purely combinational single-neuron update. Inputs are state, refr, current and threshold. Outputs are next state, next refr and spike.
- lif_array holds the storage arrays, the index mux and write-back, the output register/handshake and the counter.

## Test plan
Defaults unless stated: N = 8, W = 8, DECAY_SHIFT = 1, REFRAC = 2, RESET_MODE = 0, threshold = 32, out_ready = 1.
- Reset: rst high 2 cycles, then low → out_valid = 0, in_ready = 1, spike_count = 0. A beat of idx 5 with current 0 gives no spike.
- Integrate/fire/refractory:
  - idx 3 with current 20 on six consecutive beats. u = 20, 30, 35 → spike on beat 3, out_idx = 3 one cycle later, state = 0.
  - Beats 4–5 are refractory, state stays 0.
  - Beat 6 gives state 20. spike_count = 1.
- Saturation/subtract:
  - threshold 255, idx 0 with current 200 twice → u = 300 saturates to 255, spike.
  - RESET_MODE = 1, threshold 32, current 40 from 0 → spike, state = 8.
- Backpressure:
  - After a spike, hold out_ready = 0 with in_valid = 1 for 3 cycles → in_ready = 0, out_idx stable, no state change.
  - Raise out_ready → event consumed and the held beat accepted in the same cycle.
- Independence and range: N = 6, alternate idx 1 and 2 with current 20 each → both spike on their third beat. A beat to idx 7 is consumed with no effect and no event.
- Reset mid-operation: assert rst while out_valid = 1 → next cycle out_valid = 0, spike_count = 0. Re-driving idx 3 restarts from state 0.
